// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer
// Upstream controller for an 8:1 bit mux. It accepts a byte on a valid/ready
// handshake and drives it on mux_i. It then steps mux_s through all eight
// selects and samples mux_y once per step into a serial stream, with per-bit
// strobes and frame markers.
// Optional build macro: MUX_SEL_MSB_FIRST_EN. When defined, selects are
// stepped 7 down to 0 (MSB first). Otherwise they are stepped 0 up to 7.
module mux_sel_sequencer #(
  parameter int BIT_CYCLES = 1,   // clocks per select step, 1..256
  parameter int GAP_CYCLES = 0    // idle clocks after a frame, 0..255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic [7:0] mux_i,
  output logic [2:0] mux_s,
  input  logic       mux_y,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       frame_start,
  output logic       frame_end,
  output logic       busy
);

  // Counter widths cover the full legal parameter ranges.
  localparam int STEP_W = $clog2(256 + 1);
  localparam int GAP_W  = $clog2(255 + 1);

  // Terminal values. Both compares are exact equality.
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(BIT_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

`ifdef MUX_SEL_MSB_FIRST_EN
  localparam logic [2:0] SEL_FIRST = 3'd7;
  localparam logic [2:0] SEL_LAST  = 3'd0;

  function automatic logic [2:0] next_sel(input logic [2:0] sel);
    return sel - 3'd1;
  endfunction
`else
  localparam logic [2:0] SEL_FIRST = 3'd0;
  localparam logic [2:0] SEL_LAST  = 3'd7;

  function automatic logic [2:0] next_sel(input logic [2:0] sel);
    return sel + 3'd1;
  endfunction
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t              state_r;
  logic [STEP_W-1:0]   step_cnt_r;
  logic [GAP_W-1:0]    gap_cnt_r;
  logic [7:0]          mux_i_r;
  logic [2:0]          mux_s_r;
  logic                in_ready_r;
  logic                bit_out_r;
  logic                bit_valid_r;
  logic                frame_start_r;
  logic                frame_end_r;
  logic                busy_r;

  // Sequencer FSM: handshake, select stepping, sampling and frame pacing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      step_cnt_r    <= '0;
      gap_cnt_r     <= '0;
      mux_i_r       <= 8'h00;
      mux_s_r       <= 3'd0;
      in_ready_r    <= 1'b1;
      bit_out_r     <= 1'b0;
      bit_valid_r   <= 1'b0;
      frame_start_r <= 1'b0;
      frame_end_r   <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      // The pulse outputs are high only on the clock after a capture.
      bit_valid_r   <= 1'b0;
      frame_start_r <= 1'b0;
      frame_end_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            mux_i_r    <= in_data;
            mux_s_r    <= SEL_FIRST;
            step_cnt_r <= '0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= ST_SHIFT;
          end else begin
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (step_cnt_r == STEP_LAST) begin
            // The sample is taken in the last clock of the step.
            step_cnt_r    <= '0;
            bit_out_r     <= mux_y;
            bit_valid_r   <= 1'b1;
            frame_start_r <= (mux_s_r == SEL_FIRST);
            frame_end_r   <= (mux_s_r == SEL_LAST);
            if (mux_s_r == SEL_LAST) begin
              // mux_s holds at its final select until the next accept.
              if (GAP_CYCLES == 0) begin
                state_r    <= ST_IDLE;
                in_ready_r <= 1'b1;
                busy_r     <= 1'b0;
              end else begin
                gap_cnt_r  <= '0;
                state_r    <= ST_GAP;
              end
            end else begin
              mux_s_r <= next_sel(mux_s_r);
            end
          end else begin
            step_cnt_r <= step_cnt_r + STEP_W'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            gap_cnt_r  <= '0;
            state_r    <= ST_IDLE;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
          end else begin
            gap_cnt_r <= gap_cnt_r + GAP_W'(1);
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          in_ready_r <= 1'b1;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_r;
  assign mux_i       = mux_i_r;
  assign mux_s       = mux_s_r;
  assign bit_out     = bit_out_r;
  assign bit_valid   = bit_valid_r;
  assign frame_start = frame_start_r;
  assign frame_end   = frame_end_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// tb_mux_sel_sequencer
// Directed bench with three sequencer instances. Each instance is wired to
// its own 8:1 mux model.
//   u0: BIT_CYCLES=1, GAP_CYCLES=0
//   u1: BIT_CYCLES=3, GAP_CYCLES=0
//   u2: BIT_CYCLES=1, GAP_CYCLES=4
// Expected bit streams are given as hand-written constants, bit n at [7-n].
module tb_mux_sel_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] vld, rdy, y, bo, bv, fs, fe, bsy;
  logic [7:0] din [3];
  logic [7:0] mi  [3];
  logic [2:0] ms  [3];

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  // Combinational 8:1 mux models.
  assign y[0] = mi[0][ms[0]];
  assign y[1] = mi[1][ms[1]];
  assign y[2] = mi[2][ms[2]];

  mux_sel_sequencer #(.BIT_CYCLES(1), .GAP_CYCLES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_ready(rdy[0]), .in_data(din[0]),
    .mux_i(mi[0]), .mux_s(ms[0]), .mux_y(y[0]), .bit_out(bo[0]), .bit_valid(bv[0]),
    .frame_start(fs[0]), .frame_end(fe[0]), .busy(bsy[0]));

  mux_sel_sequencer #(.BIT_CYCLES(3), .GAP_CYCLES(0)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_ready(rdy[1]), .in_data(din[1]),
    .mux_i(mi[1]), .mux_s(ms[1]), .mux_y(y[1]), .bit_out(bo[1]), .bit_valid(bv[1]),
    .frame_start(fs[1]), .frame_end(fe[1]), .busy(bsy[1]));

  mux_sel_sequencer #(.BIT_CYCLES(1), .GAP_CYCLES(4)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[2]), .in_ready(rdy[2]), .in_data(din[2]),
    .mux_i(mi[2]), .mux_s(ms[2]), .mux_y(y[2]), .bit_out(bo[2]), .bit_valid(bv[2]),
    .frame_start(fs[2]), .frame_end(fe[2]), .busy(bsy[2]));

  // Select used for bit n of a frame.
  function automatic logic [2:0] sel_of(input int n);
`ifdef MUX_SEL_MSB_FIRST_EN
    return 3'(7 - n);
`else
    return 3'(n);
`endif
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Accept d on instance u and check the whole frame clock by clock.
  // After the accept, in_valid and in_data are set to hold and nd.
  task automatic run_frame(input int u, input logic [7:0] d, input logic [7:0] bits,
                           input int bc, input int gap, input logic hold, input logic [7:0] nd);
    logic last;
    vld[u] = 1'b1;
    din[u] = d;
    @(posedge clk); #1;
    check_eq("acc_ready", 32'(rdy[u]), 32'd0);
    check_eq("acc_busy",  32'(bsy[u]), 32'd1);
    check_eq("acc_mux_i", 32'(mi[u]),  32'(d));
    check_eq("acc_mux_s", 32'(ms[u]),  32'(sel_of(0)));
    check_eq("acc_bv",    32'(bv[u]),  32'd0);
    vld[u] = hold;
    din[u] = nd;
    for (int n = 0; n < 8; n++) begin
      for (int c = 1; c <= bc; c++) begin
        @(posedge clk); #1;
        check_eq("hold_mux_i", 32'(mi[u]), 32'(d));
        if (c < bc) begin
          check_eq("mid_bv",    32'(bv[u]), 32'd0);
          check_eq("mid_mux_s", 32'(ms[u]), 32'(sel_of(n)));
          if (n > 0) check_eq("mid_bit_hold", 32'(bo[u]), 32'(bits[8-n]));
        end else begin
          last = (n == 7);
          check_eq("bit_valid", 32'(bv[u]), 32'd1);
          check_eq("bit_out",   32'(bo[u]), 32'(bits[7-n]));
          check_eq("frame_st",  32'(fs[u]), 32'(n == 0));
          check_eq("frame_end", 32'(fe[u]), 32'(last));
          check_eq("step_mux_s", 32'(ms[u]), 32'(last ? sel_of(7) : sel_of(n + 1)));
          check_eq("bit_ready", 32'(rdy[u]), 32'(last && gap == 0));
          check_eq("bit_busy",  32'(bsy[u]), 32'(!(last && gap == 0)));
        end
      end
    end
  endtask

  initial begin
    vld = 3'b000;
    for (int u = 0; u < 3; u++) din[u] = 8'h00;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      check_eq("rst_ready", 32'(rdy[u]), 32'd1);
      check_eq("rst_busy",  32'(bsy[u]), 32'd0);
      check_eq("rst_mux_i", 32'(mi[u]),  32'h00);
      check_eq("rst_mux_s", 32'(ms[u]),  32'd0);
      check_eq("rst_bv",    32'(bv[u]),  32'd0);
      check_eq("rst_bo",    32'(bo[u]),  32'd0);
    end
    rst_n = 1'b1;

    // A5 at one clock per bit, then C3 back to back.
    run_frame(0, 8'hA5, 8'b10100101, 1, 0, 1'b0, 8'h00);
    run_frame(0, 8'hC3, 8'b11000011, 1, 0, 1'b0, 8'h00);
    @(posedge clk); #1;
    check_eq("post_bv",    32'(bv[0]), 32'd0);
    check_eq("post_fe",    32'(fe[0]), 32'd0);
    check_eq("post_ready", 32'(rdy[0]), 32'd1);
    check_eq("post_bo",    32'(bo[0]), 32'd1);

    // 81 at three clocks per bit: a 24-clock frame.
    run_frame(1, 8'h81, 8'b10000001, 3, 0, 1'b0, 8'h00);

    // FF then 00 with in_valid held, four gap clocks in between.
    run_frame(2, 8'hFF, 8'b11111111, 1, 4, 1'b1, 8'h00);
    for (int g = 1; g <= 4; g++) begin
      @(posedge clk); #1;
      check_eq("gap_ready", 32'(rdy[2]), 32'(g == 4));
      check_eq("gap_busy",  32'(bsy[2]), 32'(g < 4));
      check_eq("gap_bv",    32'(bv[2]),  32'd0);
      check_eq("gap_mux_i", 32'(mi[2]),  32'hFF);
    end
    @(posedge clk); #1;
    check_eq("acc2_mux_i", 32'(mi[2]),  32'h00);
    check_eq("acc2_ready", 32'(rdy[2]), 32'd0);
    check_eq("acc2_busy",  32'(bsy[2]), 32'd1);
    vld[2] = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      check_eq("f2_bv", 32'(bv[2]), 32'd1);
      check_eq("f2_bo", 32'(bo[2]), 32'd0);
    end
    repeat (5) @(posedge clk);
    #1;
    check_eq("f2_idle_ready", 32'(rdy[2]), 32'd1);

    // 5A aborted by reset after bit 3 has been captured.
    vld[0] = 1'b1;
    din[0] = 8'h5A;
    @(posedge clk); #1;
    check_eq("ab_mux_i", 32'(mi[0]), 32'h5A);
    vld[0] = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      check_eq("ab_bv", 32'(bv[0]), 32'd1);
      check_eq("ab_bo", 32'(bo[0]), 32'(n[0]));
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_eq("ab_ready", 32'(rdy[0]), 32'd1);
    check_eq("ab_busy",  32'(bsy[0]), 32'd0);
    check_eq("ab_mux_s", 32'(ms[0]),  32'd0);
    check_eq("ab_mux_i", 32'(mi[0]),  32'h00);
    check_eq("ab_bv_rst", 32'(bv[0]), 32'd0);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check_eq("ab_no_bv",    32'(bv[0]),  32'd0);
      check_eq("ab_idle_rdy", 32'(rdy[0]), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
